// File: rtl/lrpt_pkg.sv
// Shared LRPT soft-symbol definitions: unique word, soft levels, frame sizes,
// rotation encoding and the saturating soft negation used by rotator/derotator.
package lrpt_pkg;

  localparam logic [7:0] SOFT_ONE            = 8'h7f;
  localparam logic [7:0] SOFT_ZERO           = 8'h80;
  localparam logic [7:0] UW_WORD             = 8'h27;
  localparam int         UW_LEN              = 8;
  localparam int         BYTES_PER_FRAME_DEF = 80;
  localparam int         NUM_FRAMES_DEF      = 32;

  typedef enum logic [1:0] {
    ROT_0   = 2'd0,
    ROT_90  = 2'd1,
    ROT_180 = 2'd2,
    ROT_270 = 2'd3
  } rot_t;

  // -128 has no positive counterpart, so it saturates to +127
  function automatic logic signed [7:0] soft_neg(input logic signed [7:0] x);
    return (x == 8'sh80) ? 8'sh7f : -x;
  endfunction

  function automatic logic [7:0] uw_soft(input logic b);
    return b ? SOFT_ONE : SOFT_ZERO;
  endfunction

endpackage

// File: rtl/qpsk_rot.sv
// Combinational k*90 degree rotator for one soft (I,Q) pair; shared with the
// receive-side derotator.
module qpsk_rot
  import lrpt_pkg::*;
(
  input  rot_t              rot_i,
  input  logic signed [7:0] i_i,
  input  logic signed [7:0] q_i,
  output logic signed [7:0] i_o,
  output logic signed [7:0] q_o
);

  always_comb begin
    i_o = i_i;
    q_o = q_i;
    case (rot_i)
      ROT_90: begin
        i_o = soft_neg(q_i);
        q_o = i_i;
      end
      ROT_180: begin
        i_o = soft_neg(i_i);
        q_o = soft_neg(q_i);
      end
      ROT_270: begin
        i_o = q_i;
        q_o = soft_neg(i_i);
      end
      default: begin
        i_o = i_i;
        q_o = q_i;
      end
    endcase
  end

endmodule

// File: rtl/uw_framer.sv
// Transmit framer: buffers soft QPSK pairs, inserts the unique word at the
// start of every frame and rotates the whole frameset by a latched k*90 deg.
module uw_framer
  import lrpt_pkg::*;
#(
  parameter int         BYTES_PER_FRAME = BYTES_PER_FRAME_DEF,
  parameter int         NUM_FRAMES      = NUM_FRAMES_DEF,
  parameter logic [7:0] SYNC_WORD       = UW_WORD
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic signed [7:0] soft_in_0,
  input  logic signed [7:0] soft_in_1,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [1:0]        rot_in,
  output logic signed [7:0] soft_out,
  output logic              valid_out,
  input  logic              ready_rx,
  output logic              new_frameset
);

  localparam int SW = $clog2(BYTES_PER_FRAME);
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam logic [SW-1:0] SYM_LAST   = SW'(BYTES_PER_FRAME - 1);
  localparam logic [SW-1:0] UW_LAST    = SW'(UW_LEN - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA} state_t;

  state_t            state_q;
  logic [SW-1:0]     sym_cnt_q;
  logic [FW-1:0]     frame_cnt_q;
  rot_t              rot_q;
  logic              valid_q;
  logic signed [7:0] soft_q;
  logic              nfs_q;

  logic signed [7:0] fifo_i_q [2];
  logic signed [7:0] fifo_q_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        fill_q;
  logic [1:0]        fill_d;
  logic              ready_q;
  logic              push;
  logic              pop;
  logic              fifo_ne;

  logic              out_free;
  logic              emit;
  logic [1:0]        uw_pair;
  rot_t              rot_sel;
  logic signed [7:0] src_i;
  logic signed [7:0] src_q;
  logic signed [7:0] rot_i_val;
  logic signed [7:0] rot_q_val;
  logic signed [7:0] sym_val;

  assign push    = valid_in && ready_q;
  assign fifo_ne = (fill_q != 2'd0);
  assign fill_d  = fill_q + 2'(push) - 2'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_i_q[wr_ptr_q] <= soft_in_0;
      fifo_q_q[wr_ptr_q] <= soft_in_1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      fill_q   <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      fill_q  <= fill_d;
      ready_q <= (fill_d != 2'd2);
    end
  end

  // UW pair j carries SYNC_WORD bits 7-2j (I) and 6-2j (Q)
  assign uw_pair = sym_cnt_q[2:1];
  assign src_i   = (state_q == S_DATA) ? fifo_i_q[rd_ptr_q] : uw_soft(SYNC_WORD[{~uw_pair, 1'b1}]);
  assign src_q   = (state_q == S_DATA) ? fifo_q_q[rd_ptr_q] : uw_soft(SYNC_WORD[{~uw_pair, 1'b0}]);
  assign rot_sel = (state_q == S_IDLE) ? rot_t'(rot_in) : rot_q;

  qpsk_rot u_rot (
    .rot_i (rot_sel),
    .i_i   (src_i),
    .q_i   (src_q),
    .i_o   (rot_i_val),
    .q_o   (rot_q_val)
  );

  assign sym_val  = sym_cnt_q[0] ? rot_q_val : rot_i_val;
  assign out_free = !valid_q || ready_rx;
  assign emit     = out_free && ((state_q == S_SYNC) || (state_q != S_SYNC && fifo_ne));
  assign pop      = out_free && (state_q == S_DATA) && fifo_ne && sym_cnt_q[0];

  // The IDLE->SYNC edge already loads UW symbol 0, so SYNC resumes at symbol 1
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      sym_cnt_q   <= '0;
      frame_cnt_q <= '0;
      rot_q       <= ROT_0;
      valid_q     <= 1'b0;
      soft_q      <= '0;
      nfs_q       <= 1'b0;
    end else begin
      if (out_free) begin
        valid_q <= emit;
        nfs_q   <= emit && (state_q == S_IDLE);
        if (emit) soft_q <= sym_val;
      end
      if (emit) begin
        case (state_q)
          S_IDLE: begin
            rot_q       <= rot_t'(rot_in);
            sym_cnt_q   <= SW'(1);
            frame_cnt_q <= '0;
            state_q     <= S_SYNC;
          end
          S_SYNC: begin
            sym_cnt_q <= sym_cnt_q + SW'(1);
            if (sym_cnt_q == UW_LAST) state_q <= S_DATA;
          end
          default: begin
            if (sym_cnt_q == SYM_LAST) begin
              sym_cnt_q <= '0;
              if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_q <= '0;
                state_q     <= S_IDLE;
              end else begin
                frame_cnt_q <= frame_cnt_q + FW'(1);
                state_q     <= S_SYNC;
              end
            end else begin
              sym_cnt_q <= sym_cnt_q + SW'(1);
            end
          end
        endcase
      end
    end
  end

  assign ready_out    = ready_q;
  assign valid_out    = valid_q;
  assign soft_out     = soft_q;
  assign new_frameset = nfs_q;

endmodule

// File: tb/tb_uw_framer.sv
// Directed/table-driven bench for uw_framer with an index-based reference
// model of the framed, rotated output stream.
module tb_uw_framer;

  localparam int         BPF  = 80;
  localparam int         NF   = 32;
  localparam int         FSL  = BPF * NF;
  localparam logic [7:0] SW   = 8'h27;
  localparam int         NOUT = 2 * FSL + 200;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_in, valid_in, ready_out, valid_out, ready_rx, new_frameset;
  logic [7:0] soft_in_0, soft_in_1, soft_out;
  logic [1:0] rot_in;

  uw_framer #(.BYTES_PER_FRAME(BPF), .NUM_FRAMES(NF), .SYNC_WORD(SW)) dut (
    .clk          (clk),
    .rst_in       (rst_in),
    .soft_in_0    (soft_in_0),
    .soft_in_1    (soft_in_1),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .rot_in       (rot_in),
    .soft_out     (soft_out),
    .valid_out    (valid_out),
    .ready_rx     (ready_rx),
    .new_frameset (new_frameset)
  );

  int         checks = 0;
  int         failures = 0;
  logic [7:0] obs_s [0:8191];
  logic       obs_f [0:8191];
  int         obs_n = 0;
  int         stall_viol = 0;
  int         uw_viol = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] st_s;
  logic       st_f;
  bit         strm = 1'b0;
  bit         rx_rand = 1'b0;
  int         vprob = 100;
  int         pair_n = 0;

  typedef struct {
    int         k;
    logic [7:0] i;
    logic [7:0] q;
    logic [7:0] uw0;
    logic [7:0] d0;
    logic [7:0] d1;
  } vec_t;
  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] neg8(input logic [7:0] x);
    return (x == 8'h80) ? 8'h7f : 8'(-x);
  endfunction

  function automatic logic [7:0] rot_pick(input int k, input logic [7:0] i, input logic [7:0] q, input int sel);
    logic [7:0] a, b;
    case (k)
      0:       begin a = i;       b = q;       end
      1:       begin a = neg8(q); b = i;       end
      2:       begin a = neg8(i); b = neg8(q); end
      default: begin a = q;       b = neg8(i); end
    endcase
    return (sel != 0) ? b : a;
  endfunction

  function automatic logic [7:0] exp_sym(input int n, input int k);
    int pos, fr, j;
    logic [7:0] sw, a, b;
    sw  = SW;
    pos = n % BPF;
    fr  = n / BPF;
    if (pos < 8) begin
      j = pos / 2;
      a = sw[3'(7 - 2 * j)] ? 8'h7f : 8'h80;
      b = sw[3'(6 - 2 * j)] ? 8'h7f : 8'h80;
    end else begin
      j = fr * ((BPF - 8) / 2) + (pos - 8) / 2;
      a = 8'(2 * j);
      b = 8'(2 * j + 1);
    end
    return rot_pick(k, a, b, pos % 2);
  endfunction

  // Called at a negedge: records the transfer due at the next edge, drives
  // the next cycle's inputs after that edge, returns at the following negedge.
  task automatic step();
    logic acc;
    if (rst_in) begin
      obs_n      = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && !(valid_out && soft_out == st_s && new_frameset == st_f)) stall_viol++;
      if (!valid_out && (((obs_n % BPF) >= 1 && (obs_n % BPF) <= 7) ||
                         ((obs_n % BPF) == 0 && (obs_n % FSL) != 0))) uw_viol++;
      if (valid_out && ready_rx && obs_n < 8192) begin
        obs_s[obs_n] = soft_out;
        obs_f[obs_n] = new_frameset;
        obs_n++;
      end
      stall_prev = valid_out && !ready_rx;
      st_s       = soft_out;
      st_f       = new_frameset;
    end
    acc = strm && valid_in && ready_out && !rst_in;
    @(posedge clk);
    #1;
    if (acc) pair_n++;
    if (strm) begin
      valid_in  = ($urandom_range(99) < vprob);
      soft_in_0 = 8'(2 * pair_n);
      soft_in_1 = 8'(2 * pair_n + 1);
    end
    ready_rx = rx_rand ? 1'($urandom_range(1)) : 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int guard, m, tp_lows, k;

    vt[0] = '{0, 8'h10, 8'h80, 8'h80, 8'h10, 8'h80};
    vt[1] = '{1, 8'h10, 8'h80, 8'h7f, 8'h7f, 8'h10};
    vt[2] = '{2, 8'h10, 8'h80, 8'h7f, 8'hf0, 8'h7f};
    vt[3] = '{3, 8'h10, 8'h80, 8'h80, 8'h80, 8'hf0};
    vt[4] = '{2, 8'h05, 8'h80, 8'h7f, 8'hfb, 8'h7f};
    vt[5] = '{0, 8'h7f, 8'h81, 8'h80, 8'h7f, 8'h81};
    vt[6] = '{1, 8'h7f, 8'h81, 8'h7f, 8'h7f, 8'h7f};
    vt[7] = '{2, 8'h00, 8'h01, 8'h7f, 8'h00, 8'hff};
    vt[8] = '{3, 8'h22, 8'hc0, 8'h80, 8'hc0, 8'hde};
    vt[9] = '{1, 8'h80, 8'h80, 8'h7f, 8'h7f, 8'h80};

    rst_in = 1'b1; valid_in = 1'b1; soft_in_0 = 8'h11; soft_in_1 = 8'h22;
    ready_rx = 1'b1; rot_in = 2'd0;
    @(negedge clk);
    repeat (3) step();
    chk("reset_valid_out", valid_out, 1'b0);
    chk("reset_soft_out", soft_out, 8'h00);
    chk("reset_new_frameset", new_frameset, 1'b0);
    chk("reset_ready_out", ready_out, 1'b0);
    valid_in = 1'b0;
    rst_in   = 1'b0;
    step();
    chk("ready_after_reset", ready_out, 1'b1);
    repeat (3) step();
    chk("valid_in_ignored_in_reset", valid_out, 1'b0);

    for (int v = 0; v < 10; v++) begin
      rst_in = 1'b1; valid_in = 1'b0; rot_in = 2'(vt[v].k);
      step(); step();
      rst_in = 1'b0;
      step();
      soft_in_0 = vt[v].i; soft_in_1 = vt[v].q; valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      chk($sformatf("vec%0d_lat_t1_valid", v), valid_out, 1'b0);
      step();
      chk($sformatf("vec%0d_lat_t2_valid", v), valid_out, 1'b1);
      chk($sformatf("vec%0d_uw0", v), soft_out, vt[v].uw0);
      chk($sformatf("vec%0d_new_frameset", v), new_frameset, 1'b1);
      guard = 0;
      while (obs_n < 10 && guard < 40) begin step(); guard++; end
      chk($sformatf("vec%0d_out_count", v), 32'(obs_n >= 10), 1);
      m = 0;
      for (int j = 0; j < 8; j++) if (obs_s[j] !== exp_sym(j, vt[v].k)) m++;
      chk($sformatf("vec%0d_uw_seq_errs", v), m, 0);
      chk($sformatf("vec%0d_d0", v), obs_s[8], vt[v].d0);
      chk($sformatf("vec%0d_d1", v), obs_s[9], vt[v].d1);
    end

    // Streaming: full rate first, then random valid/ready; rot_in moves at symbol 100
    rst_in = 1'b1; valid_in = 1'b0; rx_rand = 1'b0; rot_in = 2'd0;
    step(); step();
    rst_in = 1'b0; pair_n = 0; vprob = 100; strm = 1'b1;
    guard = 0;
    while (!valid_out && guard < 20) begin step(); guard++; end
    chk("stream_first_valid", valid_out, 1'b1);
    tp_lows = 0;
    for (int c = 0; c < 250; c++) begin
      if (!valid_out) tp_lows++;
      if (obs_n >= 100) rot_in = 2'd2;
      step();
    end
    chk("full_rate_bubbles", tp_lows, 0);
    vprob = 70; rx_rand = 1'b1;
    guard = 0;
    while (obs_n < NOUT && guard < 30000) begin step(); guard++; end
    chk("stream_out_count", 32'(obs_n >= NOUT), 1);
    m = 0;
    for (int n = 0; n < NOUT && n < obs_n; n++) begin
      k = (n < FSL) ? 0 : 2;
      if (obs_s[n] !== exp_sym(n, k)) begin
        if (m == 0) $display("FAIL stream_data first at %0d: got %0h expected %0h", n, obs_s[n], exp_sym(n, k));
        m++;
      end
    end
    chk("stream_data_errs", m, 0);
    m = 0;
    for (int n = 0; n < NOUT && n < obs_n; n++) if (obs_f[n] !== ((n % FSL) == 0)) m++;
    chk("stream_new_frameset_errs", m, 0);

    // Reset at frame 3 symbol 45
    rx_rand = 1'b0; vprob = 100; rot_in = 2'd0;
    rst_in = 1'b1;
    step(); step();
    rst_in = 1'b0; pair_n = 0;
    guard = 0;
    while (obs_n < 3 * BPF + 45 && guard < 1000) begin step(); guard++; end
    chk("midreset_reach", obs_n, 3 * BPF + 45);
    chk("midreset_sym45", soft_out, exp_sym(3 * BPF + 45, 0));
    rst_in = 1'b1;
    step();
    chk("midreset_valid_out", valid_out, 1'b0);
    chk("midreset_soft_out", soft_out, 8'h00);
    chk("midreset_ready_out", ready_out, 1'b0);
    rst_in = 1'b0;
    guard = 0;
    while (obs_n < 8 && guard < 40) begin step(); guard++; end
    chk("restart_count", 32'(obs_n >= 8), 1);
    m = 0;
    for (int j = 0; j < 8; j++) if (obs_s[j] !== exp_sym(j, 0)) m++;
    chk("restart_uw_errs", m, 0);
    chk("restart_new_frameset", obs_f[0], 1'b1);

    strm = 1'b0; valid_in = 1'b0;
    chk("stall_hold_violations", stall_viol, 0);
    chk("uw_stall_violations", uw_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
